// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup, update and statistics signals of the branch predictor
//   master: fetch/resolve side, drives pc_i and upd_*, receives pred_* and counts
//   slave : predictor side
interface branch_predictor_if #(
    parameter int STAT_W = 16
);
    logic [31:0]       pc_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [31:0]       pred_target_o;
    logic              upd_valid_i;
    logic [31:0]       upd_pc_i;
    logic              upd_taken_i;
    logic [31:0]       upd_target_i;
    logic              upd_pred_taken_i;
    logic [31:0]       upd_pred_target_i;
    logic [STAT_W-1:0] br_cnt_o;
    logic [STAT_W-1:0] mispred_cnt_o;
    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        input  pred_hit_o, pred_taken_o, pred_target_o, br_cnt_o, mispred_cnt_o
    );
    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        output pred_hit_o, pred_taken_o, pred_target_o, br_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters and hit/mispredict statistics
//   clk_i, rst_i : clock, synchronous active-high reset
//   bp (slave)   : combinational lookup of pc_i, one resolved-branch update per cycle, statistics counts
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input logic clk_i,
    input logic rst_i,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [STAT_W-1:0] r_br_cnt;
    logic [STAT_W-1:0] r_mis_cnt;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_hit;
    logic             w_taken;
    logic             w_uhit;
    logic             w_mis;
    logic             w_unused;
    assign w_idx  = bp.pc_i[IDX_W+1:2];
    assign w_tag  = bp.pc_i[31:IDX_W+2];
    assign w_uidx = bp.upd_pc_i[IDX_W+1:2];
    assign w_utag = bp.upd_pc_i[31:IDX_W+2];
    assign w_unused = ^{bp.pc_i[1:0], bp.upd_pc_i[1:0]};
    // Lookup reads registered state only; an update in this cycle is seen next cycle.
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_taken = w_hit && r_cnt[w_idx][CNT_W-1];
    assign w_uhit  = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_mis   = (bp.upd_pred_taken_i != bp.upd_taken_i) ||
                     (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i));
    assign bp.pred_hit_o    = w_hit;
    assign bp.pred_taken_o  = w_taken;
    assign bp.pred_target_o = w_taken ? r_target[w_idx] : bp.pc_i + 32'd4;
    assign bp.br_cnt_o      = r_br_cnt;
    assign bp.mispred_cnt_o = r_mis_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else if (bp.upd_valid_i) begin
            r_br_cnt <= (r_br_cnt != '1) ? r_br_cnt + STAT_W'(1) : r_br_cnt;
            if (w_mis && (r_mis_cnt != '1))
                r_mis_cnt <= r_mis_cnt + STAT_W'(1);
            if (w_uhit) begin
                if (bp.upd_taken_i) begin
                    r_cnt[w_uidx]    <= (r_cnt[w_uidx] != '1) ? r_cnt[w_uidx] + CNT_W'(1) : r_cnt[w_uidx];
                    r_target[w_uidx] <= bp.upd_target_i;
                end else begin
                    r_cnt[w_uidx] <= (r_cnt[w_uidx] != '0) ? r_cnt[w_uidx] - CNT_W'(1) : r_cnt[w_uidx];
                end
            end else if (bp.upd_taken_i) begin
                // Taken miss allocates (or evicts an alias) as weakly taken.
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bp.upd_target_i;
                r_cnt[w_uidx]    <= CNT_WT;
            end
        end
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the number of BTB/BHT entries (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 2, giving the width of each saturating direction counter (at least 1).
REQ-003 The block SHALL have parameter STAT_W, default 16, giving the width of each statistics counter.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port pc_i, input, 32 bits: the IF-stage fetch PC being looked up.
REQ-007 The block SHALL have port pred_hit_o, output, 1 bit: the entry at pc_i's index is valid and its tag matches.
REQ-008 The block SHALL have port pred_taken_o, output, 1 bit: predicted taken.
REQ-009 The block SHALL have port pred_target_o, output, 32 bits: the predicted next PC.
REQ-010 The block SHALL have port upd_valid_i, input, 1 bit: a resolved branch is being reported this cycle.
REQ-011 The block SHALL have port upd_pc_i, input, 32 bits: the PC of the resolved branch.
REQ-012 The block SHALL have port upd_taken_i, input, 1 bit: the actual branch outcome.
REQ-013 The block SHALL have port upd_target_i, input, 32 bits: the actual taken target.
REQ-014 The block SHALL have port upd_pred_taken_i, input, 1 bit: the direction originally predicted for this branch.
REQ-015 The block SHALL have port upd_pred_target_i, input, 32 bits: the next PC originally predicted for this branch.
REQ-016 The block SHALL have port br_cnt_o, output, STAT_W bits: the count of resolved branches.
REQ-017 The block SHALL have port mispred_cnt_o, output, STAT_W bits: the count of mispredictions.

Function
REQ-018 The block SHALL use IDX_W = log2(ENTRIES), index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2]; bits [1:0] are ignored.
REQ-019 Each entry SHALL hold a valid bit, a tag, a 32-bit target and a CNT_W-bit counter.
REQ-020 Lookup SHALL be combinational from the registered table state, with no bypass from an update in the same cycle.
REQ-021 On lookup, if hit and counter MSB=1, pred_taken_o SHALL be 1 and pred_target_o SHALL be the stored target; otherwise pred_taken_o SHALL be 0 and pred_target_o SHALL be pc_i+4 (mod 2^32).
REQ-022 An update with upd_valid_i=1 and a hit on upd_pc_i SHALL increment the counter on taken, saturating at 2^CNT_W-1, and decrement it on not-taken, saturating at 0.
REQ-023 An update that hits with upd_taken_i=1 SHALL also write upd_target_i into the entry's target.
REQ-024 An update that misses (invalid or tag mismatch) with taken=1 SHALL allocate or overwrite the entry: valid=1, new tag, target=upd_target_i, counter=2^(CNT_W-1) (weakly taken).
REQ-025 An update that misses with taken=0 SHALL leave the table unchanged.
REQ-026 Updates SHALL become visible to lookup on the cycle after the update edge (latency 1).
REQ-027 On each update, br_cnt_o SHALL increment by 1, saturating at all-ones.
REQ-028 mispredict SHALL be defined as (upd_pred_taken_i != upd_taken_i) OR (upd_taken_i AND upd_pred_target_i != upd_target_i).
REQ-029 On each update where mispredict is true, mispred_cnt_o SHALL increment by 1, saturating at all-ones.
REQ-030 Only one update per cycle SHALL be accepted; upd_* inputs are ignored when upd_valid_i=0.

Reset
REQ-031 While rst_i=1 at a clock edge, the block SHALL clear all valid bits, set all counters to 2^(CNT_W-1)-1, and set all targets, tags, br_cnt_o and mispred_cnt_o to 0.
REQ-032 rst_i SHALL take priority over a simultaneous update, which is discarded.
REQ-033 During and after reset, outputs SHALL be pred_hit_o=0, pred_taken_o=0, pred_target_o=pc_i+4 and both counts 0.

Verification
REQ-034 The bench SHALL cover post-reset lookup: pc_i=0x40 -> hit=0, taken=0, target=0x44, br_cnt=0, mispred_cnt=0.
REQ-035 The bench SHALL cover allocation: update pc=0x40, taken=1, target=0x80, pred_taken=0, pred_target=0x44 -> next cycle lookup 0x40 gives hit=1, taken=1, target=0x80, br_cnt=1, mispred_cnt=1.
REQ-036 The bench SHALL cover counter saturation (CNT_W=2): after three further taken updates (counter=3), one not-taken update -> still taken; a second not-taken update -> counter=1, taken=0, target=0x44.
REQ-037 The bench SHALL cover aliasing (ENTRIES=16): lookup 0x80 -> hit=0 while the 0x40 entry is valid; update 0x80, taken=1, target=0x100 -> 0x80 hits with target 0x100 and 0x40 now misses.
REQ-038 The bench SHALL cover a same-cycle lookup and update of the same PC: the lookup returns the pre-update value and the new value appears the next cycle.
REQ-039 The bench SHALL cover reset with priority and saturation: rst_i=1 with upd_valid_i=1 -> all lookups miss and counts are 0; with STAT_W=4, 20 mispredicting updates -> br_cnt_o=15 and mispred_cnt_o=15, both holding.
